// File: rtl/reaction_timer_multi.sv
// N-player reaction timer: random wait, then times the first responder in ms ticks.
// Tracks early presses, timeout, latency-compensated result and the session best.
module reaction_timer_multi #(
  parameter int          N_PLAYERS  = 2,
  parameter int          TICK_DIV   = 50000,
  parameter int          TIME_W     = 14,
  parameter int          MAX_TIME   = 9999,
  parameter int          DELAY_MIN  = 1000,
  parameter logic [15:0] DELAY_MASK = 16'h0FFF,
  parameter int          OFFSET     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] response,
  output logic                 ready_led,
  output logic                 test_led,
  output logic [N_PLAYERS-1:0] early_led,
  output logic                 overflow_led,
  output logic [N_PLAYERS-1:0] winner,
  output logic [TIME_W-1:0]    rect_time,
  output logic                 time_valid,
  output logic [TIME_W-1:0]    best_time
);

  localparam int W2    = TIME_W + 2;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] MAX_T    = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] MAX_M1   = TIME_W'(MAX_TIME - 1);
  localparam logic [W2-1:0]     MAX_W    = W2'(MAX_TIME);
  localparam logic [W2-1:0]     OFF_W    = W2'(OFFSET);
  localparam logic [W2-1:0]     DMIN_W   = W2'(DELAY_MIN);

  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, EARLY} state_t;

  state_t                 state;
  logic [15:0]            lfsr;
  logic                   start_q;
  logic [N_PLAYERS-1:0]   resp_q;
  logic [PRE_W-1:0]       pre;
  logic [W2-1:0]          wait_cnt;
  logic [TIME_W-1:0]      time_cnt;

  logic                   start_edge;
  logic [N_PLAYERS-1:0]   resp_edge;
  logic [N_PLAYERS-1:0]   first_resp;
  logic                   tick;
  logic                   lfsr_fb;
  logic [W2-1:0]          wait_load;
  logic [W2-1:0]          sum;
  logic [TIME_W-1:0]      sat_time;

  always_comb begin
    start_edge = start & ~start_q;
    resp_edge  = response & ~resp_q;
    // Isolate the lowest set bit so simultaneous presses favour the lowest index.
    first_resp = resp_edge & (~resp_edge + N_PLAYERS'(1));
    tick       = (pre == PRE_LAST);
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    wait_load  = DMIN_W + W2'(lfsr & DELAY_MASK);
    sum        = W2'(time_cnt) + OFF_W;
    sat_time   = (sum > MAX_W) ? MAX_T : sum[TIME_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= 16'hACE1;
      // Capture the live button levels so a press held through reset is not an edge.
      start_q      <= start;
      resp_q       <= response;
      pre          <= '0;
      wait_cnt     <= '0;
      time_cnt     <= '0;
      ready_led    <= 1'b1;
      test_led     <= 1'b0;
      early_led    <= '0;
      overflow_led <= 1'b0;
      winner       <= '0;
      rect_time    <= '0;
      time_valid   <= 1'b0;
      best_time    <= MAX_T;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      start_q    <= start;
      resp_q     <= response;
      time_valid <= 1'b0;
      pre        <= tick ? '0 : pre + PRE_W'(1);

      case (state)
        IDLE, DONE, EARLY: begin
          if (start_edge) begin
            state        <= ARMED;
            wait_cnt     <= wait_load;
            early_led    <= '0;
            winner       <= '0;
            overflow_led <= 1'b0;
            ready_led    <= 1'b0;
            pre          <= '0;
          end
        end

        ARMED: begin
          if (|resp_edge) begin
            state     <= EARLY;
            early_led <= resp_edge;
            ready_led <= 1'b1;
            pre       <= '0;
          end else if (tick) begin
            // The tick that brings the count to zero is the one that fires.
            if (wait_cnt <= W2'(1)) begin
              state    <= TIMING;
              time_cnt <= '0;
              test_led <= 1'b1;
              pre      <= '0;
            end else begin
              wait_cnt <= wait_cnt - W2'(1);
            end
          end
        end

        TIMING: begin
          if (|resp_edge) begin
            state      <= DONE;
            winner     <= first_resp;
            rect_time  <= sat_time;
            time_valid <= 1'b1;
            if (sat_time < best_time) best_time <= sat_time;
            test_led   <= 1'b0;
            ready_led  <= 1'b1;
            pre        <= '0;
          end else if (tick) begin
            if (time_cnt == MAX_M1) begin
              state        <= DONE;
              overflow_led <= 1'b1;
              winner       <= '0;
              rect_time    <= MAX_T;
              time_valid   <= 1'b1;
              test_led     <= 1'b0;
              ready_led    <= 1'b1;
              pre          <= '0;
            end else begin
              time_cnt <= time_cnt + TIME_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi with a result scoreboard checked on time_valid.
module tb_reaction_timer_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  response;
  logic        ready_led, test_led, overflow_led, time_valid;
  logic [1:0]  early_led, winner;
  logic [13:0] rect_time, best_time;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0]  w;
    logic [13:0] t;
    logic        o;
    logic [13:0] b;
  } exp_t;

  exp_t sb[$];

  reaction_timer_multi #(
    .N_PLAYERS (2),
    .TICK_DIV  (4),
    .TIME_W    (14),
    .MAX_TIME  (20),
    .DELAY_MIN (3),
    .DELAY_MASK(16'h0003),
    .OFFSET    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .response    (response),
    .ready_led   (ready_led),
    .test_led    (test_led),
    .early_led   (early_led),
    .overflow_led(overflow_led),
    .winner      (winner),
    .rect_time   (rect_time),
    .time_valid  (time_valid),
    .best_time   (best_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_test(output int cyc);
    cyc = 0;
    while (!test_led && cyc < 60) begin
      tick1();
      cyc++;
    end
    check("test_led_rise", 32'(test_led), 32'd1);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready_led && cyc < 120) begin
      tick1();
      cyc++;
    end
    check("ready_after_round", 32'(ready_led), 32'd1);
  endtask

  task automatic new_round();
    start = 1'b1;
    tick1();
    start = 1'b0;
  endtask

  // From one step after TIMING entry, press so time_cnt equals ms when the edge lands.
  task automatic press_at(input int ms, input logic [1:0] val);
    repeat (4 * ms + 1) tick1();
    response = val;
    tick1();
    response = 2'b00;
    repeat (2) tick1();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready_led), 32'd1);
    check({tag, "_test"},  32'(test_led), 32'd0);
    check({tag, "_early"}, 32'(early_led), 32'd0);
    check({tag, "_ovf"},   32'(overflow_led), 32'd0);
    check({tag, "_win"},   32'(winner), 32'd0);
    check({tag, "_rect"},  32'(rect_time), 32'd0);
    check({tag, "_valid"}, 32'(time_valid), 32'd0);
    check({tag, "_best"},  32'(best_time), 32'd20);
  endtask

  always @(negedge clk) begin
    if (time_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_time_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_winner",   32'(winner), 32'(e.w));
        check("sb_rect",     32'(rect_time), 32'(e.t));
        check("sb_overflow", 32'(overflow_led), 32'(e.o));
        check("sb_best",     32'(best_time), 32'(e.b));
      end
    end
  end

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    start = 1'b0;
    response = 2'b00;
    repeat (3) tick1();
    check_reset_state("reset");

    // Round 1: start edge on the first cycle after reset uses LFSR = ACE1 -> 4 ms wait.
    rst = 1'b0;
    start = 1'b1;
    wait_test(cyc);
    start = 1'b0;
    check("armed_to_test_cycles", 32'(cyc), 32'd17);  // 1 to enter ARMED + 16
    check("ready_low_timing", 32'(ready_led), 32'd0);
    sb.push_back('{w: 2'b10, t: 14'd12, o: 1'b0, b: 14'd12});
    press_at(7, 2'b10);
    check("r1_test_off", 32'(test_led), 32'd0);
    check("r1_ready", 32'(ready_led), 32'd1);

    // Round 2: simultaneous press, lowest index wins.
    new_round();
    wait_test(cyc);
    sb.push_back('{w: 2'b01, t: 14'd7, o: 1'b0, b: 14'd7});
    press_at(2, 2'b11);

    // Round 3: early press while armed.
    new_round();
    response = 2'b01;
    tick1();
    response = 2'b00;
    check("early_led", 32'(early_led), 32'd1);
    check("early_ready", 32'(ready_led), 32'd1);
    seen = 0;
    repeat (40) begin
      tick1();
      if (test_led) seen++;
    end
    check("early_no_test", 32'(seen), 32'd0);
    check("early_rect_hold", 32'(rect_time), 32'd7);
    check("early_best_hold", 32'(best_time), 32'd7);
    check("early_win_clear", 32'(winner), 32'd0);

    // Round 4: timeout.
    new_round();
    check("early_cleared", 32'(early_led), 32'd0);
    wait_test(cyc);
    sb.push_back('{w: 2'b00, t: 14'd20, o: 1'b1, b: 14'd7});
    wait_ready(cyc);
    check("overflow_cycles", 32'(cyc), 32'd80);
    check("overflow_led", 32'(overflow_led), 32'd1);
    tick1();

    // Round 5: press lands on the overflow tick; response wins.
    new_round();
    check("ovf_cleared", 32'(overflow_led), 32'd0);
    wait_test(cyc);
    sb.push_back('{w: 2'b01, t: 14'd20, o: 1'b0, b: 14'd7});
    repeat (79) tick1();
    response = 2'b01;
    tick1();
    response = 2'b00;
    check("edge_on_ovf_no_ovf", 32'(overflow_led), 32'd0);
    repeat (2) tick1();

    // Round 6: reset mid-TIMING with buttons held.
    new_round();
    wait_test(cyc);
    repeat (5) tick1();
    rst = 1'b1;
    response = 2'b11;
    tick1();
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (10) tick1();
    check("no_spurious_win", 32'(winner), 32'd0);
    check("no_spurious_ready", 32'(ready_led), 32'd1);
    new_round();
    repeat (2) tick1();
    response = 2'b00;
    check("held_not_early", 32'(early_led), 32'd0);
    wait_test(cyc);
    sb.push_back('{w: 2'b01, t: 14'd9, o: 1'b0, b: 14'd9});
    press_at(4, 2'b01);

    new_round();
    wait_test(cyc);
    sb.push_back('{w: 2'b10, t: 14'd15, o: 1'b0, b: 14'd9});
    press_at(10, 2'b10);
    repeat (3) tick1();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
